// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns load/store flags into a req/ack handshake,
// stalls the pipeline until the ack arrives, and aborts hung accesses after TIMEOUT cycles.
module mem_access_ctrl #(
   parameter int N       = 32,
   parameter int M       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         regw_M,
   input  logic         memw_M,
   input  logic         regmem_M,
   input  logic [M-1:0] regScr_M,
   input  logic [N-1:0] ALUrslt_M,
   input  logic [N-1:0] address_M,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_rdata,
   output logic         stall_M,
   output logic         regw_W,
   output logic [M-1:0] regScr_W,
   output logic [N-1:0] result_W,
   output logic         err_M
);

   typedef enum logic {IDLE, REQ} state_t;

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   state_t       state;
   logic [N-1:0] hold_addr;
   logic [N-1:0] hold_data;
   logic         hold_we;
   logic         hold_regw;
   logic [M-1:0] hold_rd;
   logic [7:0]   cnt;

   logic pending;
   logic at_limit;

   assign pending  = memw_M | regmem_M;
   assign at_limit = (cnt == LIMIT);

   // Request outputs come straight from state and holding registers, so a reset
   // in REQ drops them without waiting for a clock.
   assign mem_req   = (state == REQ);
   assign mem_we    = mem_req & hold_we;
   assign mem_addr  = mem_req ? hold_addr : '0;
   assign mem_wdata = mem_req ? hold_data : '0;

   always_comb begin
      stall_M = 1'b0;
      if (state == IDLE)
         stall_M = pending;
      else
         stall_M = ~mem_ack & ~at_limit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_addr <= '0;
         hold_data <= '0;
         hold_we   <= 1'b0;
         hold_regw <= 1'b0;
         hold_rd   <= '0;
         cnt       <= '0;
         regw_W    <= 1'b0;
         regScr_W  <= '0;
         result_W  <= '0;
         err_M     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  hold_addr <= address_M;
                  hold_data <= ALUrslt_M;
                  hold_we   <= memw_M;
                  hold_regw <= regw_M;
                  hold_rd   <= regScr_M;
                  cnt       <= '0;
                  regw_W    <= 1'b0;
                  state     <= REQ;
               end else begin
                  regw_W   <= regw_M;
                  regScr_W <= regScr_M;
                  result_W <= ALUrslt_M;
               end
            end
            REQ: begin
               // An ack always wins over the abort, even in the last allowed cycle.
               if (mem_ack) begin
                  result_W <= hold_we ? hold_data : mem_rdata;
                  regw_W   <= hold_regw;
                  regScr_W <= hold_rd;
                  state    <= IDLE;
               end else if (at_limit) begin
                  regw_W <= 1'b0;
                  err_M  <= 1'b1;
                  state  <= IDLE;
               end else begin
                  regw_W <= 1'b0;
                  cnt    <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
